// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling of a 2-flop-synchronised rx line, start/DBIT data/stop
// deserialisation, byte and framing-error flag presented with a one-cycle done strobe.
module uart_rx #(
  parameter int DBIT    = 8,   // data bits per frame (5..8)
  parameter int SB_TICK = 16   // s_ticks spent in the stop state
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  localparam int S_W = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state;
  logic [S_W-1:0] s;
  logic [2:0]     n;
  logic [7:0]     b;
  logic           rx_meta;
  logic           rx_s;

  // Synchroniser flops reset to the idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes the previous flop's old value -- two real stages.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      // NOTE: strobe defaults low every cycle; only the stop-exit branch raises it for one clk.
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_W'(7)) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;  // glitch shorter than half a bit
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_W'(15)) begin
              s <= '0;
              b <= {rx_s, b[7:1]};
              if (n == 3'(DBIT - 1)) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_W'(SB_TICK - 1)) begin
              state        <= IDLE;
              s            <= '0;
              dout         <= b >> (8 - DBIT);
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a line driver pushes expected bytes to a scoreboard queue,
// an independent monitor pops and compares on every rx_done_tick.
module tb_uart_rx;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  int tests    = 0;
  int fails    = 0;
  int strobes  = 0;
  int tick_div = 0;
  int s0;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // One s_tick pulse every 4 clk.
  initial begin
    forever begin
      @(negedge clk);
      s_tick   = (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        strobes++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got strobe with dout=0x%0h, expected none", dout);
        end else begin
          e = sb_q.pop_front();
          check("sb_dout", {24'h0, dout}, {24'h0, e.data});
          check("sb_frame_err", {31'h0, frame_err}, {31'h0, e.err});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Returns 1 ns after the n-th subsequent s_tick edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // Drives one frame starting right after a tick. abort_bit >= 0 resets the link mid data bit.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int abort_bit);
    exp_t e;
    if (abort_bit < 0) begin
      e.data = data;
      e.err  = !stop_ok;
      sb_q.push_back(e);
    end
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == abort_bit) begin
        wait_ticks(6);
        reset = 1'b1;
        rx    = 1'b1;
        return;
      end
      wait_ticks(16);
    end
    rx = stop_ok;
    wait_ticks(8);
    @(negedge clk);
    check("strobe_at_stop_tick8", {31'h0, rx_done_tick}, 32'h1);
    if (stop_ok) begin
      wait_ticks(8);
    end else begin
      wait_ticks(4);
      rx = 1'b1;
      wait_ticks(4);
    end
  endtask

  initial begin
    // Power-on reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_done", {31'h0, rx_done_tick}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    idle_ticks(4);

    send_frame(8'hA5, 1'b1, -1);
    idle_ticks(8);

    // Short low pulse must be rejected.
    s0 = strobes;
    rx = 1'b0;
    wait_ticks(4);
    idle_ticks(16);
    check("glitch_no_strobe", strobes, s0);
    check("glitch_dout_held", {24'h0, dout}, 32'hA5);
    send_frame(8'h3C, 1'b1, -1);
    idle_ticks(8);

    // Framing error then recovery.
    send_frame(8'h5A, 1'b0, -1);
    idle_ticks(24);
    check("ferr_held", {31'h0, frame_err}, 32'h1);
    send_frame(8'h01, 1'b1, -1);
    idle_ticks(8);

    // Reset mid-run clears outputs at once, then a quiet idle line.
    reset = 1'b1;
    #1;
    check("midrst_dout", {24'h0, dout}, 32'h0);
    check("midrst_done", {31'h0, rx_done_tick}, 32'h0);
    check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    s0 = strobes;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle_no_strobe", strobes, s0);
    idle_ticks(4);

    // Back-to-back frames, zero idle gap.
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    idle_ticks(8);

    // Reset during data bit 3, then a clean frame.
    s0 = strobes;
    send_frame(8'hC3, 1'b1, 3);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_ticks(20);
    check("abort_no_strobe", strobes, s0);
    check("abort_dout_cleared", {24'h0, dout}, 32'h0);
    send_frame(8'hC3, 1'b1, -1);
    idle_ticks(8);

    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
